// File: rtl/taylor_pkg.sv
// Shared constants, state encoding and coefficient table for the cosine
// Taylor-series engine.
//   W       : angle_in / cos_out width (unsigned Q1.23)
//   FRAC    : fractional bits of every fixed-point quantity
//   N_TERMS : non-constant series terms (x^2 .. x^10)
//   ONE     : 1.0 at the term width
//   coef()  : C_k = 1/((2k-1)(2k)) in Q0.23
package taylor_pkg;

    localparam int unsigned W       = 24;
    localparam int unsigned FRAC    = 23;
    localparam int unsigned N_TERMS = 5;

    // Term width (unsigned Q2.23), accumulator width (signed Q4.23), term index width
    localparam int unsigned TW = FRAC + 2;
    localparam int unsigned AW = FRAC + 5;
    localparam int unsigned KW = 3;

    localparam logic [TW-1:0] ONE = TW'(1) << FRAC;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        MULX,
        MULC,
        ACC,
        DONE
    } state_t;

    // Per-term scale factor; index 0 and anything past N_TERMS are never used
    function automatic logic [FRAC-1:0] coef(input logic [KW-1:0] k);
        case (k)
            3'd1:    coef = FRAC'(4194304);
            3'd2:    coef = FRAC'(699051);
            3'd3:    coef = FRAC'(279620);
            3'd4:    coef = FRAC'(149797);
            3'd5:    coef = FRAC'(93207);
            default: coef = '0;
        endcase
    endfunction

endpackage

// File: rtl/fxp_mul.sv
// Unsigned fixed-point multiplier: prod_c = (a * b) >> SHIFT, truncating,
// purely combinational.
//   a      : multiplicand, A_W bits
//   b      : multiplier, B_W bits
//   prod_c : shifted product, P_W bits (upper bits beyond P_W discarded)
module fxp_mul
    import taylor_pkg::*;
#(
    parameter int unsigned A_W   = TW,
    parameter int unsigned B_W   = TW,
    parameter int unsigned P_W   = TW,
    parameter int unsigned SHIFT = FRAC
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] prod_c
);

    localparam int unsigned FULL_W = A_W + B_W;

    logic [FULL_W-1:0] full;

    // Full-width product, then drop the fraction and keep the low P_W bits
    assign full   = FULL_W'(a) * FULL_W'(b);
    assign prod_c = P_W'(full >> SHIFT);

endmodule

// File: rtl/taylor_series.sv
// Iterative cosine by Taylor series: cos(x) = 1 - x^2/2! + ... - x^10/10!.
// One shared multiplier is time-multiplexed across squaring, the x^2 step and
// the coefficient step of each term.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   start     : level launch request, honoured only while idle
//   angle_in  : angle in radians, unsigned Q1.23, sampled at launch
//   ready_out : one-cycle pulse with each new cos_out
//   cos_out   : registered result, unsigned Q1.23, clamped to [0, 1.0]
module taylor_series
    import taylor_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] angle_in,
    output logic         ready_out,
    output logic [W-1:0] cos_out
);

    localparam logic signed [AW-1:0] ACC_ONE = AW'(ONE);

    state_t                state;
    state_t                state_next;
    logic                  launch_c;

    logic [W-1:0]          x;
    logic [TW-1:0]         x2;
    logic [TW-1:0]         t;
    logic signed [AW-1:0]  acc;
    logic [KW-1:0]         k;

    logic [TW-1:0]         mul_a;
    logic [TW-1:0]         mul_b;
    logic [TW-1:0]         mul_p;
    logic signed [AW-1:0]  t_ext;
    logic [W-1:0]          clamp_c;

    // The cycle presenting a result is not treated as idle, so a held start
    // yields one result every 19 cycles
    assign launch_c = (state == IDLE) && start && !ready_out;

    // Shared multiplier operand selection
    always_comb begin
        mul_a = t;
        mul_b = x2;
        case (state)
            SQ: begin
                mul_a = TW'(x);
                mul_b = TW'(x);
            end
            MULC:    mul_b = TW'(coef(k));
            default: ;
        endcase
    end

    fxp_mul #(
        .A_W   (TW),
        .B_W   (TW),
        .P_W   (TW),
        .SHIFT (FRAC)
    ) u_mul (
        .a      (mul_a),
        .b      (mul_b),
        .prod_c (mul_p)
    );

    assign t_ext = $signed({{(AW-TW){1'b0}}, t});

    // Saturate the signed accumulator into the unsigned output range
    always_comb begin
        clamp_c = W'(acc);
        if (acc[AW-1]) begin
            clamp_c = '0;
        end else if (acc > ACC_ONE) begin
            clamp_c = W'(ONE);
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch_c) state_next = SQ;
            SQ:      state_next = MULX;
            MULX:    state_next = MULC;
            MULC:    state_next = ACC;
            ACC:     state_next = (k < KW'(N_TERMS)) ? MULX : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            x         <= '0;
            x2        <= '0;
            t         <= '0;
            acc       <= '0;
            k         <= '0;
            cos_out   <= '0;
            ready_out <= 1'b0;
        end else begin
            ready_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_c) begin
                        x   <= angle_in;
                        t   <= ONE;
                        acc <= ACC_ONE;
                        k   <= KW'(1);
                    end
                end
                SQ:         x2 <= mul_p;
                MULX, MULC: t  <= mul_p;
                ACC: begin
                    // Odd terms carry a negative sign
                    acc <= k[0] ? (acc - t_ext) : (acc + t_ext);
                    k   <= k + KW'(1);
                end
                DONE: begin
                    cos_out   <= clamp_c;
                    ready_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_taylor_series.sv
// Self-checking bench for taylor_series: directed and random angles against a
// fixed-point reference of the series plus a real-valued cosine.
module tb_taylor_series;

    localparam longint SCALE = 64'd8388608;
    localparam longint LIM16 = 64'd13421773;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] angle_in;
    logic        ready_out;
    logic [23:0] cos_out;

    int checks = 0;
    int errors = 0;

    taylor_series dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .angle_in  (angle_in),
        .ready_out (ready_out),
        .cos_out   (cos_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic [23:0] obs, input longint exp, input longint tol);
        longint o;
        longint d;
        o = longint'(obs);
        d = (o > exp) ? (o - exp) : (exp - o);
        checks++;
        assert (!$isunknown(obs) && d <= tol) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Series evaluated with plain integer arithmetic at the stated widths:
    // 25-bit unsigned terms, 28-bit signed accumulator, truncating shifts
    function automatic longint model_cos(input longint a);
        longint c [5] = '{64'd4194304, 64'd699051, 64'd279620, 64'd149797, 64'd93207};
        longint m25 = (64'd1 << 25) - 1;
        longint m28 = (64'd1 << 28) - 1;
        longint x2;
        longint t;
        longint acc;
        x2  = ((a * a) >> 23) & m25;
        t   = SCALE;
        acc = SCALE;
        for (int k = 1; k <= 5; k++) begin
            t   = ((t * x2) >> 23) & m25;
            t   = ((t * c[k-1]) >> 23) & m25;
            acc = (k % 2 == 1) ? acc - t : acc + t;
            acc = acc & m28;
            if (acc >= (64'd1 << 27)) acc = acc - (64'd1 << 28);
        end
        if (acc < 0) return 0;
        if (acc > SCALE) return SCALE;
        return acc;
    endfunction

    function automatic longint real_cos(input longint a);
        real r;
        r = $cos(real'(a) / 8388608.0);
        return longint'($rtoi(r * 8388608.0 + 0.5));
    endfunction

    // Launch with angle a, optionally disturb inputs mid-run, wait for the pulse
    task automatic run(input logic [23:0] a, input bit scr, output int lat, output logic [23:0] val);
        angle_in = a;
        start    = 1'b1;
        lat      = -1;
        val      = 'x;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (ready_out === 1'b1) begin
                lat = i;
                val = cos_out;
                break;
            end
            if (scr && i <= 10) begin
                angle_in = 24'($urandom);
                start    = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        check("pulse_width", {63'b0, ready_out}, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [23:0] val;
        logic [23:0] a;
        logic [23:0] held;
        int          pulses;
        int          last;
        longint      m;

        reset    = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_ready", {63'b0, ready_out}, 64'd0);
        check("reset_cos", {40'b0, cos_out}, 64'd0);

        // First launch on the first edge with reset low
        reset = 1'b0;
        run(24'h400000, 1'b0, lat, val);
        check("lat_0p5", 64'(lat), 64'd17);
        check("model_0p5", {40'b0, val}, 64'(model_cos(64'h400000)));
        check_tol("spec_0p5", val, 64'd7361696, 64'd16);

        run(24'h000000, 1'b0, lat, val);
        check("cos_zero", {40'b0, val}, 64'd8388608);

        run(24'h800000, 1'b0, lat, val);
        check("model_1p0", {40'b0, val}, 64'(model_cos(64'h800000)));
        check_tol("spec_1p0", val, 64'd4532384, 64'd16);

        run(24'hC00000, 1'b0, lat, val);
        check("model_1p5", {40'b0, val}, 64'(model_cos(64'hC00000)));
        check_tol("spec_1p5", val, 64'd593387, 64'd16);

        // Inputs disturbed during the computation must not matter
        run(24'h400000, 1'b1, lat, val);
        check("lat_scramble", 64'(lat), 64'd17);
        check("model_scramble", {40'b0, val}, 64'(model_cos(64'h400000)));

        // Random angles inside the accuracy range
        for (int n = 0; n < 10; n++) begin
            a = 24'($urandom_range(0, 32'(LIM16)));
            run(a, n[0], lat, val);
            check("lat_rand", 64'(lat), 64'd17);
            check("model_rand", {40'b0, val}, 64'(model_cos(64'(a))));
            check_tol("acc_rand", val, real_cos(64'(a)), 64'd16);
        end

        // Angles past the accuracy range: exact model match, clamped, no X
        for (int n = 0; n < 4; n++) begin
            a = (n == 0) ? 24'hF00000 : 24'($urandom_range(32'(LIM16) + 1, 32'hFFFFFF));
            run(a, 1'b0, lat, val);
            check("lat_big", 64'(lat), 64'd17);
            check("nox_big", {63'b0, $isunknown(val)}, 64'd0);
            check("range_big", {63'b0, (val <= 24'h800000)}, 64'd1);
            check("model_big", {40'b0, val}, 64'(model_cos(64'(a))));
        end

        // Start held high: 19-cycle cadence, 1-cycle pulses, stable output
        a        = 24'hB00000;
        m        = model_cos(64'(a));
        angle_in = a;
        start    = 1'b1;
        pulses   = 0;
        last     = 0;
        held     = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock);
            #1;
            if (ready_out === 1'b1) begin
                if (pulses == 0) check("held_first", 64'(c), 64'd18);
                else             check("held_gap", 64'(c - last), 64'd19);
                check("held_cos", {40'b0, cos_out}, 64'(m));
                pulses++;
                last = c;
                held = cos_out;
            end else if (pulses > 0) begin
                check("held_stable", {40'b0, cos_out}, {40'b0, held});
            end
        end
        check("held_count", 64'(pulses), 64'd3);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset2_cos", {40'b0, cos_out}, 64'd0);

        // Reset 8 cycles after launch aborts the run
        run(24'h200000, 1'b0, lat, val);
        angle_in = 24'h600000;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_ready", {63'b0, ready_out}, 64'd0);
        check("abort_cos", {40'b0, cos_out}, 64'd0);
        reset  = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clock);
            #1;
            if (ready_out !== 1'b0) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        run(24'h600000, 1'b0, lat, val);
        check("lat_after_abort", 64'(lat), 64'd17);
        check("model_after_abort", {40'b0, val}, 64'(model_cos(64'h600000)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/taylor_series.md
TAYLOR_SERIES -- requirements
Module: taylor_series

Interface
REQ-001 Parameter W, default 24: width of angle_in and cos_out.
REQ-002 Parameter FRAC, default 23: fractional bits; a value v is encoded as round(v * 2^23), unsigned Q1.23.
REQ-003 Parameter N_TERMS, default 5: number of non-constant Taylor terms (x^2 .. x^10).
REQ-004 clock  input  1  single clock; all logic updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level request; a computation launches on any rising edge where the block is idle and start=1.
REQ-007 ready_out  output  1  one-cycle pulse marking a new valid cos_out.
REQ-008 angle_in  input  W  angle in radians, unsigned Q1.23; sampled only at launch.
REQ-009 cos_out  output  W  cos(angle_in), unsigned Q1.23; registered.

Function
REQ-010 Compute cos(x) = 1 - x^2/2! + x^4/4! - x^6/6! + x^8/8! - x^10/10! iteratively: t0 = 1.0; t_k = t_(k-1) * x^2 * C_k; acc = sum of (-1)^k * t_k.
REQ-011 C_k = 1/((2k-1)(2k)) in Q0.23: C1=4194304, C2=699051, C3=279620, C4=149797, C5=93207.
REQ-012 States: IDLE, SQ, MULX, MULC, ACC, DONE.
REQ-013 IDLE: if start=1, latch angle_in into x, set t=1.0, acc=1.0, k=1, go to SQ; otherwise stay in IDLE.
REQ-014 SQ: x2 = (x*x) >> 23, held unsigned in 25 bits (Q2.23); go to MULX.
REQ-015 MULX: t = (t*x2) >> 23.
REQ-016 MULC: t = (t*C_k) >> 23.
REQ-017 ACC: acc = acc - t for odd k, acc + t for even k; go to MULX with k+1 if k < N_TERMS, else go to DONE.
REQ-018 Datapath widths: t is unsigned Q2.23 (25 bits); acc is signed Q4.23 (28 bits); products are full width; each shift truncates toward zero.
REQ-019 DONE: register cos_out = acc clamped to [0, 2^23] and assert ready_out for exactly this cycle; next state is IDLE.
REQ-020 Latency: ready_out is high in the cycle following the 17th rising edge after the launch edge.
REQ-021 Between ready_out pulses, cos_out holds its last value.
REQ-022 If start is held high, the block relaunches on every pass through IDLE: one result every 19 cycles.
REQ-023 angle_in and start changes during a computation are ignored.
REQ-024 Accuracy: for 0 <= angle_in <= 1.6 rad, |cos_out - round(cos(x)*2^23)| <= 16 LSB.
REQ-025 Angles above 1.6 rad are computed without error and clamped; accuracy is unspecified there, and negative results read as 0.

Reset
REQ-026 While reset=1 at a rising edge: state becomes IDLE, ready_out=0, cos_out=0, x, x2, t, acc and k become 0.
REQ-027 Reset asserted mid-computation aborts it; no ready_out pulse is produced for the aborted request.
REQ-028 The first launch is possible on the first rising edge with reset=0 and start=1.

Structure
REQ-029 Package taylor_pkg shall hold W, FRAC, N_TERMS, the ONE constant (2^23), the C_k table and the state enum typedef.
REQ-030 One sub-module, fxp_mul: unsigned fixed-point multiply, (a*b) >> FRAC, truncating, combinational; it is shared by SQ, MULX and MULC through an operand mux.
REQ-031 There are no other sub-modules; the FSM and accumulator live in taylor_series.

Verification
REQ-032 reset for 1 cycle, angle_in=0x400000 (0.5), start held high -> first ready_out 17 cycles after launch, cos_out = 7361696 +/- 16.
REQ-033 angle_in=0 -> cos_out = 8388608 (0x800000) exactly; angle_in=0x800000 (1.0) -> 4532384 +/- 16; angle_in=0xC00000 (1.5) -> 593387 +/- 16.
REQ-034 start held high -> ready_out pulses exactly 1 cycle wide, 19 cycles apart; cos_out stable between pulses.
REQ-035 Change angle_in mid-computation -> result matches the angle sampled at launch.
REQ-036 reset asserted 8 cycles after launch -> ready_out=0 and cos_out=0 next cycle, no pulse for the aborted run; a new launch afterwards gives a correct result.
REQ-037 angle_in=0xF00000 (1.875) -> no X values, cos_out within [0, 8388608], ready_out pulse occurs.
